// File: rtl/timeout_sched_pkg.sv
// Shared types and helpers for the timeout scheduler.
package timeout_sched_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        EXPIRED,
        RELEASE
    } sched_state_e;

    localparam int unsigned DEFAULT_CW = 32;

    // Encodes a one-hot vector of up to eight bits into its index.
    function automatic logic [2:0] onehot_to_idx(input logic [7:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (oh[i]) idx = idx | 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set req bit after 'last', wrapping.
module rr_pick #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last,
    output logic [IW-1:0]   sel,
    output logic            valid
);

    int unsigned w_idx;

    // Scan from farthest to nearest so the nearest set bit after 'last' wins.
    always_comb begin
        sel   = '0;
        valid = 1'b0;
        w_idx = 0;
        for (int unsigned k = NREQ; k >= 1; k--) begin
            w_idx = (32'(last) + k) % NREQ;
            if (req[w_idx]) begin
                sel   = IW'(w_idx);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/timeout_scheduler.sv
// Shares one timeout counter between NREQ requesters with round-robin grant.
module timeout_scheduler
    import timeout_sched_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned CW   = DEFAULT_CW
) (
    input  logic               clock,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ-1:0]    done,
    input  logic [NREQ*CW-1:0] req_len,
    output logic [NREQ-1:0]    grant,
    output logic               busy,
    output logic [CW-1:0]      elapsed,
    output logic [NREQ-1:0]    timeout_pulse,
    output logic [NREQ-1:0]    timeout_flag
);

    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    sched_state_e    r_state,   w_state_nxt;
    logic [NREQ-1:0] r_grant,   w_grant_nxt;
    logic [CW-1:0]   r_elapsed, w_elapsed_nxt;
    logic [CW-1:0]   r_len,     w_len_nxt;
    logic [NREQ-1:0] r_pulse,   w_pulse_nxt;
    logic [NREQ-1:0] r_flag,    w_flag_nxt;
    logic [IW-1:0]   r_last,    w_last_nxt;

    logic [IW-1:0]   w_pick_sel;
    logic            w_pick_valid;
    logic [7:0]      w_grant8;
    logic [IW-1:0]   w_sel;

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr_pick (
        .req   (req),
        .last  (r_last),
        .sel   (w_pick_sel),
        .valid (w_pick_valid)
    );

    // The granted index is recovered from the one-hot grant rather than stored twice.
    always_comb begin
        w_grant8             = '0;
        w_grant8[NREQ-1:0]   = r_grant;
        w_sel                = IW'(onehot_to_idx(w_grant8));
    end

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_grant   <= '0;
            r_elapsed <= '0;
            r_len     <= '0;
            r_pulse   <= '0;
            r_flag    <= '0;
            r_last    <= IW'(NREQ - 1);
        end else begin
            r_state   <= w_state_nxt;
            r_grant   <= w_grant_nxt;
            r_elapsed <= w_elapsed_nxt;
            r_len     <= w_len_nxt;
            r_pulse   <= w_pulse_nxt;
            r_flag    <= w_flag_nxt;
            r_last    <= w_last_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_grant_nxt   = r_grant;
        w_elapsed_nxt = r_elapsed;
        w_len_nxt     = r_len;
        w_pulse_nxt   = '0;
        w_flag_nxt    = r_flag;
        w_last_nxt    = r_last;

        case (r_state)
            IDLE: begin
                w_elapsed_nxt = '0;
                if (w_pick_valid) begin
                    w_grant_nxt             = '0;
                    w_grant_nxt[w_pick_sel] = 1'b1;
                    w_len_nxt               = req_len[w_pick_sel*CW +: CW];
                    w_state_nxt             = RUN;
                end
            end
            RUN: begin
                if (done[w_sel] || !req[w_sel]) begin
                    w_grant_nxt   = '0;
                    w_elapsed_nxt = '0;
                    w_last_nxt    = w_sel;
                    w_state_nxt   = RELEASE;
                end else if ((r_len != '0) && (r_elapsed == r_len - CW'(1))) begin
                    w_elapsed_nxt       = r_len;
                    w_pulse_nxt[w_sel]  = 1'b1;
                    w_flag_nxt[w_sel]   = 1'b1;
                    w_state_nxt         = EXPIRED;
                end else if (r_elapsed != '1) begin
                    w_elapsed_nxt = r_elapsed + CW'(1);
                end
            end
            EXPIRED: begin
                if (!req[w_sel]) begin
                    w_grant_nxt   = '0;
                    w_flag_nxt    = '0;
                    w_elapsed_nxt = '0;
                    w_last_nxt    = w_sel;
                    w_state_nxt   = RELEASE;
                end
            end
            RELEASE: begin
                w_elapsed_nxt = '0;
                w_state_nxt   = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign grant         = r_grant;
    assign busy          = |r_grant;
    assign elapsed       = r_elapsed;
    assign timeout_pulse = r_pulse;
    assign timeout_flag  = r_flag;

endmodule

// File: tb/tb_timeout_scheduler.sv
// Directed self-checking bench for timeout_scheduler.
module tb_timeout_scheduler;

    localparam int unsigned NREQ = 4;
    localparam int unsigned CW   = 32;

    logic               clock;
    logic               rst_n;
    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    done;
    logic [NREQ*CW-1:0] req_len;
    logic [NREQ-1:0]    grant;
    logic               busy;
    logic [CW-1:0]      elapsed;
    logic [NREQ-1:0]    timeout_pulse;
    logic [NREQ-1:0]    timeout_flag;

    int n_checks = 0;
    int n_pass   = 0;

    timeout_scheduler #(
        .NREQ (NREQ),
        .CW   (CW)
    ) dut (
        .clock         (clock),
        .rst_n         (rst_n),
        .req           (req),
        .done          (done),
        .req_len       (req_len),
        .grant         (grant),
        .busy          (busy),
        .elapsed       (elapsed),
        .timeout_pulse (timeout_pulse),
        .timeout_flag  (timeout_flag)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else
            n_pass++;
    endtask

    // Advance one edge; outputs are sampled 1 time unit after it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_len(input int unsigned i, input logic [CW-1:0] v);
        req_len[i*CW +: CW] = v;
    endtask

    logic [NREQ-1:0] pulse_seen;
    logic [NREQ-1:0] rr_exp [5];
    int lows;

    initial begin
        rst_n   = 1'b0;
        req     = '0;
        done    = '0;
        req_len = '0;
        tick();
        tick();
        check("rst_grant",   32'(grant), 32'h0);
        check("rst_busy",    32'(busy), 32'h0);
        check("rst_elapsed", elapsed, 32'h0);
        check("rst_pulse",   32'(timeout_pulse), 32'h0);
        check("rst_flag",    32'(timeout_flag), 32'h0);
        rst_n = 1'b1;
        tick();

        // Single window ended by done after three granted cycles
        set_len(1, 5);
        req = 4'b0010;
        tick();
        check("w1_grant", 32'(grant), 32'h2);
        check("w1_busy",  32'(busy), 32'h1);
        check("w1_e0",    elapsed, 32'd0);
        done = 4'b0001;
        tick();
        check("w1_foreign_done", 32'(grant), 32'h2);
        done = 4'b0000;
        tick();
        check("w1_e2",    elapsed, 32'd2);
        done = 4'b0010;
        tick();
        check("w1_rel_grant",   32'(grant), 32'h0);
        check("w1_rel_elapsed", elapsed, 32'd0);
        check("w1_rel_pulse",   32'(timeout_pulse), 32'h0);
        done = '0;
        req  = '0;
        tick();
        check("w1_idle", 32'(grant), 32'h0);

        // Expiry with length changed mid-window (must be ignored)
        set_len(2, 4);
        req = 4'b0100;
        tick();
        check("w2_grant", 32'(grant), 32'h4);
        set_len(2, 2);
        tick();
        tick();
        check("w2_no_early", 32'(timeout_pulse), 32'h0);
        tick();
        check("w2_e3",    elapsed, 32'd3);
        check("w2_pre",   32'(timeout_pulse), 32'h0);
        tick();
        check("w2_pulse", 32'(timeout_pulse), 32'h4);
        check("w2_flag",  32'(timeout_flag), 32'h4);
        check("w2_e4",    elapsed, 32'd4);
        done = 4'b0100;
        tick();
        check("w2_pulse_1cyc", 32'(timeout_pulse), 32'h0);
        check("w2_flag_hold",  32'(timeout_flag), 32'h4);
        check("w2_e_frozen",   elapsed, 32'd4);
        check("w2_done_ign",   32'(grant), 32'h4);
        done = '0;
        req  = '0;
        tick();
        check("w2_rel_grant", 32'(grant), 32'h0);
        check("w2_rel_flag",  32'(timeout_flag), 32'h0);
        tick();

        // Length 0 never expires
        set_len(3, 0);
        req = 4'b1000;
        pulse_seen = '0;
        tick();
        check("w3_grant", 32'(grant), 32'h8);
        for (int i = 0; i < 99; i++) begin
            tick();
            pulse_seen = pulse_seen | timeout_pulse;
        end
        check("w3_e99",  elapsed, 32'd99);
        check("w3_nopulse", 32'(pulse_seen), 32'h0);
        check("w3_noflag",  32'(timeout_flag), 32'h0);
        done = 4'b1000;
        tick();
        check("w3_rel", 32'(grant), 32'h0);
        done = '0;
        req  = '0;
        tick();

        // Round robin with all requesters held high
        for (int i = 0; i < 4; i++) set_len(i, 0);
        rr_exp[0] = 4'b0001;
        rr_exp[1] = 4'b0010;
        rr_exp[2] = 4'b0100;
        rr_exp[3] = 4'b1000;
        rr_exp[4] = 4'b0001;
        req = 4'b1111;
        for (int w = 0; w < 5; w++) begin
            lows = 0;
            while (grant == '0 && lows < 8) begin
                lows++;
                tick();
            end
            check($sformatf("rr_grant%0d", w), 32'(grant), 32'(rr_exp[w]));
            if (w > 0) check($sformatf("rr_gap%0d", w), 32'(lows), 32'd2);
            tick();
            done = rr_exp[w];
            tick();
            done = '0;
            check($sformatf("rr_rel%0d", w), 32'(grant), 32'h0);
        end
        req = '0;
        tick();

        // done coincides with the expiry cycle: done wins
        set_len(0, 3);
        req = 4'b0001;
        tick();
        check("w4_grant", 32'(grant), 32'h1);
        tick();
        tick();
        check("w4_e2", elapsed, 32'd2);
        done = 4'b0001;
        tick();
        check("w4_grant0", 32'(grant), 32'h0);
        check("w4_nopulse", 32'(timeout_pulse), 32'h0);
        check("w4_noflag",  32'(timeout_flag), 32'h0);
        done = '0;
        req  = '0;
        tick();

        // Reset in the middle of a window
        set_len(0, 10);
        set_len(1, 10);
        req = 4'b0001;
        tick();
        for (int i = 0; i < 5; i++) tick();
        check("w5_e5", elapsed, 32'd5);
        rst_n = 1'b0;
        tick();
        check("w5_rst_grant", 32'(grant), 32'h0);
        check("w5_rst_busy",  32'(busy), 32'h0);
        check("w5_rst_e",     elapsed, 32'd0);
        check("w5_rst_pulse", 32'(timeout_pulse), 32'h0);
        check("w5_rst_flag",  32'(timeout_flag), 32'h0);
        rst_n = 1'b1;
        req   = 4'b0011;
        tick();
        check("w5_first", 32'(grant), 32'h1);
        req = '0;
        tick();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
